// File: rtl/vga_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctrl_pkg
// Description : Shared types and constants for the VGA mode controller:
//               mode width, FSM state encoding, button indices, the
//               auto-cycle frame period and the mode stepping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_ctrl_pkg;

  localparam int MODE_W = 3;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    REQ        = 2'd2
  } state_t;

  // Bit positions inside the 4-bit button vector
  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_PAUSE = 2;
  localparam int BTN_HOME  = 3;

  // Frames between automatic mode advances (auto-cycle build only)
  localparam int AUTO_FRAMES = 60;

  // Navigation operations that move the target mode
  typedef enum logic [1:0] {
    NAV_NEXT = 2'd0,
    NAV_PREV = 2'd1,
    NAV_HOME = 2'd2
  } nav_t;

  // Apply one navigation step to a mode value; 'last' is NUM_MODES-1.
  function automatic logic [MODE_W-1:0] mode_step(
    input logic [MODE_W-1:0] cur,
    input nav_t              op,
    input logic [MODE_W-1:0] last
  );
    logic [MODE_W-1:0] r;
    r = cur;
    case (op)
      NAV_NEXT: r = (cur == last) ? '0 : cur + MODE_W'(1);
      NAV_PREV: r = (cur == '0) ? last : cur - MODE_W'(1);
      NAV_HOME: r = '0;
      default:  r = cur;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Single push-button conditioner. Two-flop synchroniser on the
//               raw active-low pin, a stable-level counter, and a rising-edge
//               detector that emits a one-cycle press pulse.
//               Pin-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
// Ports       : clk_i    - system clock
//               reset_i  - asynchronous active-high reset
//               btn_n_i  - raw active-low button pin
//               press_o  - one-cycle pulse on released-to-pressed transition
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;     // synchroniser, reset to released (pin high)
  logic          stable_q;   // accepted level, 1 = pressed
  logic          prev_q;     // stable_q delayed, for edge detection
  logic [CW-1:0] cnt_q;      // cycles the synchronised level has differed
  logic          press_q;
  logic          lvl_w;

  assign lvl_w   = ~sync_q[1];
  assign press_o = press_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      prev_q  <= stable_q;
      press_q <= stable_q & ~prev_q;
      // Any return to the accepted level restarts the qualification window
      if (lvl_w == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= lvl_w;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_mode_ctrl
// Description : Push-button front end for the VGA datapath. Debounces
//               B2..B5, arbitrates simultaneous presses (B5 > B4 > B2 > B3),
//               tracks the pause flag and commits display-mode changes to
//               vga_top through a req/ack handshake aligned to the end of
//               the vertical sync pulse.
//               Optional macro VGA_MODE_AUTOCYCLE_EN adds an automatic
//               "next mode" every AUTO_FRAMES frames while idle and running.
// Ports       : clk_i       - 50 MHz system clock
//               reset_i     - asynchronous active-high reset
//               btn_n_i     - raw buttons, active low: [0]=next [1]=prev
//                             [2]=pause toggle [3]=home
//               v_sync_i    - active-low vertical sync
//               mode_ack_i  - one-cycle pulse, vga_top latched mode_o
//               mode_o      - committed display mode
//               mode_req_o  - request to apply mode_o
//               pause_o     - freeze-animation flag
//               busy_o      - FSM not idle
//               err_o       - sticky acknowledge-timeout flag
//               evt_drop_o  - one-cycle pulse when button events are lost
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_MODES       = 8,
  parameter int ACK_TIMEOUT     = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        btn_n_i,
  input  logic              v_sync_i,
  input  logic              mode_ack_i,
  output logic [MODE_W-1:0] mode_o,
  output logic              mode_req_o,
  output logic              pause_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              evt_drop_o
);

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic [3:0] btn_ev_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn_n_i (btn_n_i[gi]),
      .press_o (btn_ev_w[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Frame boundary: rising edge of synchronised v_sync (end of sync pulse).
  // Reset high so leaving reset never fakes an edge.
  // --------------------------------------------------------------------------
  logic [2:0] vs_q;
  logic       frame_w;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vs_q <= 3'b111;
    end else begin
      vs_q <= {vs_q[1:0], v_sync_i};
    end
  end

  assign frame_w = vs_q[1] & ~vs_q[2];

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] target_q;
  logic [TW-1:0]     tmo_q;
  logic              req_q;
  logic              pause_q;
  logic              err_q;
  logic              drop_q;

  // --------------------------------------------------------------------------
  // Optional automatic mode advance
  // --------------------------------------------------------------------------
  logic auto_w;

`ifdef VGA_MODE_AUTOCYCLE_EN
  logic [5:0] frame_cnt_q;
  logic       auto_tick_w;

  assign auto_tick_w = frame_w & (state_q == IDLE) & ~pause_q;
  assign auto_w      = auto_tick_w & (frame_cnt_q == 6'(AUTO_FRAMES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      frame_cnt_q <= '0;
    end else if (|btn_ev_w) begin
      // User activity restarts the idle period
      frame_cnt_q <= '0;
    end else if (auto_tick_w) begin
      frame_cnt_q <= auto_w ? 6'd0 : frame_cnt_q + 6'd1;
    end
  end
`else
  assign auto_w = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: exactly one event is taken per cycle
  // --------------------------------------------------------------------------
  logic              take_home_w;
  logic              take_pause_w;
  logic              take_next_w;
  logic              take_prev_w;
  logic              take_auto_w;
  logic              nav_btn_w;     // a button navigation event was taken
  logic              nav_any_w;     // button or automatic navigation
  logic              multi_w;       // two or more button events collided
  nav_t              nav_op_w;
  logic [MODE_W-1:0] from_mode_w;
  logic [MODE_W-1:0] from_tgt_w;
  logic [MODE_W-1:0] tgt_eff_w;

  always_comb begin
    take_home_w  = btn_ev_w[BTN_HOME];
    take_pause_w = btn_ev_w[BTN_PAUSE] & ~btn_ev_w[BTN_HOME];
    take_next_w  = btn_ev_w[BTN_NEXT] & ~btn_ev_w[BTN_HOME] & ~btn_ev_w[BTN_PAUSE];
    take_prev_w  = btn_ev_w[BTN_PREV] & ~btn_ev_w[BTN_HOME] & ~btn_ev_w[BTN_PAUSE]
                 & ~btn_ev_w[BTN_NEXT];
    // The automatic advance loses to any button and is discarded silently
    take_auto_w  = auto_w & ~(|btn_ev_w);
    nav_btn_w    = take_home_w | take_next_w | take_prev_w;
    nav_any_w    = nav_btn_w | take_auto_w;
    // x & (x-1) clears the lowest set bit: non-zero means at least two events
    multi_w      = |(btn_ev_w & (btn_ev_w - 4'd1));

    nav_op_w = NAV_PREV;
    if (take_home_w) begin
      nav_op_w = NAV_HOME;
    end else if (take_next_w | take_auto_w) begin
      nav_op_w = NAV_NEXT;
    end

    from_mode_w = mode_step(mode_q, nav_op_w, LAST_MODE);
    from_tgt_w  = mode_step(target_q, nav_op_w, LAST_MODE);
    tgt_eff_w   = nav_any_w ? from_tgt_w : target_q;
  end

  // --------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      target_q <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      // One pulse covers every event lost this cycle
      drop_q <= multi_w | ((state_q == REQ) & nav_btn_w);

      if (take_pause_w) begin
        pause_q <= ~pause_q;
      end

      case (state_q)
        IDLE: begin
          // Home while already at mode 0 is a no-op
          if (nav_any_w && (from_mode_w != mode_q)) begin
            target_q <= from_mode_w;
            state_q  <= WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          // An event coinciding with the boundary is folded into the commit
          target_q <= tgt_eff_w;
          if (frame_w) begin
            mode_q  <= tgt_eff_w;
            req_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= REQ;
          end
        end

        REQ: begin
          if (mode_ack_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            // Give up; the new mode is kept as committed
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mode_o     = mode_q;
  assign mode_req_o = req_q;
  assign pause_o    = pause_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign evt_drop_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mode_ctrl
// Description : Self-checking bench for vga_mode_ctrl. Stimulus queues the
//               expected handshake (mode, request length, err after it);
//               a monitor pops and compares on every request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mode_ctrl;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] btn_n   = 4'hF;
  logic       v_sync  = 1'b1;
  logic       ack     = 1'b0;
  logic [2:0] mode_o;
  logic       mode_req_o;
  logic       pause_o;
  logic       busy_o;
  logic       err_o;
  logic       evt_drop_o;

  always #5 clk = ~clk;

  vga_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .NUM_MODES       (8),
    .ACK_TIMEOUT     (16)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .btn_n_i    (btn_n),
    .v_sync_i   (v_sync),
    .mode_ack_i (ack),
    .mode_o     (mode_o),
    .mode_req_o (mode_req_o),
    .pause_o    (pause_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .evt_drop_o (evt_drop_o)
  );

  typedef struct {
    logic [2:0] mode;
    int         len;
    logic       err;
  } hs_t;

  hs_t exp_q[$];
  int  errors    = 0;
  int  checks    = 0;
  int  hs_done   = 0;
  int  drops     = 0;
  int  ack_delay = 0;
  int  d0        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    btn_n = ~m;
    tick(10);
    btn_n = 4'hF;
    tick(10);
  endtask

  task automatic frame();
    tick(20);
    v_sync = 1'b0;
    tick(3);
    v_sync = 1'b1;
    tick(2);
  endtask

  task automatic push(input logic [2:0] m, input int len, input logic e);
    hs_t h;
    h.mode = m;
    h.len  = len;
    h.err  = e;
    exp_q.push_back(h);
  endtask

  task automatic wait_hs(input int n);
    int k;
    k = 0;
    while (hs_done < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("hs_count", hs_done, n);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (mode_req_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", mode_req_o, 1);
  endtask

  // Scoreboard monitor: one entry per observed request
  hs_t m_e;
  int  m_len;
  int  m_have;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mode_req_o === 1'b1) begin
        m_have = exp_q.size();
        if (m_have == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request for mode %0d, expected none", mode_o);
        end else begin
          m_e = exp_q.pop_front();
          check("hs_mode", mode_o, m_e.mode);
        end
        m_len = 0;
        while (mode_req_o === 1'b1 && m_len < 100) begin
          m_len++;
          @(negedge clk);
        end
        if (m_have != 0) begin
          check("hs_req_len", m_len, m_e.len);
          check("hs_err", err_o, m_e.err);
          check("hs_busy_after", busy_o, 0);
        end
        hs_done++;
      end
    end
  end

  initial begin : drop_mon
    forever begin
      @(negedge clk);
      if (evt_drop_o === 1'b1) drops++;
    end
  end

  // Acknowledge responder; ack_delay==0 withholds the ack
  logic resp_prev = 1'b0;
  initial begin : responder
    forever begin
      @(negedge clk);
      if (mode_req_o === 1'b1 && !resp_prev && ack_delay > 0) begin
        repeat (ack_delay) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
      end
      resp_prev = mode_req_o;
    end
  end

  initial begin : stim
    tick(3);
    @(negedge clk);
    check("rst_mode", mode_o, 0);
    check("rst_req", mode_req_o, 0);
    check("rst_pause", pause_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_drop", evt_drop_o, 0);
    tick(1);
    rst = 1'b0;
    tick(5);

    // Bouncing B2 never qualifies
    for (int i = 0; i < 6; i++) begin
      btn_n[0] = ~btn_n[0];
      tick(2);
    end
    btn_n = 4'hF;
    tick(20);
    check("bounce_mode", mode_o, 0);
    check("bounce_busy", busy_o, 0);
    check("bounce_drops", drops, 0);

    // B2: 0 -> 1, ack 3 cycles after req
    ack_delay = 3;
    push(3'd1, 4, 1'b0);
    press(4'b0001);
    frame();
    wait_hs(1);
    check("next_mode", mode_o, 1);

    // B5: 1 -> 0
    ack_delay = 1;
    push(3'd0, 2, 1'b0);
    press(4'b1000);
    frame();
    wait_hs(2);

    // B3 wraps 0 -> 7
    push(3'd7, 2, 1'b0);
    press(4'b0010);
    frame();
    wait_hs(3);
    check("prev_wrap_mode", mode_o, 7);

    // Two B2 presses before one boundary: 7 -> 0 -> 1, single handshake
    push(3'd1, 2, 1'b0);
    press(4'b0001);
    press(4'b0001);
    frame();
    wait_hs(4);

    // Reach mode 3, then B5+B2 together
    push(3'd3, 2, 1'b0);
    press(4'b0001);
    press(4'b0001);
    frame();
    wait_hs(5);
    d0 = drops;
    push(3'd0, 2, 1'b0);
    press(4'b1001);
    frame();
    wait_hs(6);
    check("collide_drops", drops - d0, 1);
    check("collide_mode", mode_o, 0);

    // B5 at mode 0 does nothing
    press(4'b1000);
    @(negedge clk);
    check("home_noop_busy", busy_o, 0);
    frame();
    tick(5);
    check("home_noop_req", mode_req_o, 0);
    check("home_noop_hs", hs_done, 6);

    // B4 toggles pause without a handshake
    d0 = drops;
    press(4'b0100);
    @(negedge clk);
    check("pause_set", pause_o, 1);
    check("pause_busy", busy_o, 0);
    check("pause_drops", drops - d0, 0);

    // Ack withheld: timeout, plus a B2 dropped while in REQ
    ack_delay = 0;
    push(3'd1, 16, 1'b1);
    d0 = drops;
    press(4'b0001);
    frame();
    wait_req();
    press(4'b0001);
    wait_hs(7);
    check("req_drop", drops - d0, 1);
    check("tmo_err", err_o, 1);
    check("tmo_mode_kept", mode_o, 1);
    tick(30);
    @(negedge clk);
    check("err_sticky", err_o, 1);
    check("tmo_no_retry", mode_req_o, 0);
    check("tmo_idle", busy_o, 0);

    // Reset while in REQ
    push(3'd2, 4, 1'b0);
    press(4'b0001);
    frame();
    wait_req();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mode", mode_o, 0);
    check("arst_req", mode_req_o, 0);
    check("arst_pause", pause_o, 0);
    check("arst_err", err_o, 0);
    check("arst_busy", busy_o, 0);
    tick(2);
    rst = 1'b0;
    wait_hs(8);
    tick(1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(3);
    @(negedge clk);
    check("stray_ack_req", mode_req_o, 0);
    check("stray_ack_busy", busy_o, 0);
    check("stray_ack_mode", mode_o, 0);

    tick(10);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
